io_port_bridge: RTL and testbench
=================================

Name: io_port_bridge

Overview:
- External/device-side end of the CPU IN/OUT port interface; sits between the execute-memory stage port signals and off-chip peripherals.
- Input path: buffers words offered by an external device in a small FIFO; each CPU IN instruction consumes one word.
- Output path: takes each CPU OUT word and presents it to the external device with a valid/ready handshake until accepted.
- Status and sticky error flags go to the hazard/interrupt logic.

Parameters:
- DATA_WIDTH, 16, port word width.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_ext_in_valid  in  1  external device offers a word.
- i_ext_in_data  in  DATA_WIDTH  offered word.
- o_ext_in_ready  out  1  bridge can accept; combinational, equals !full.
- i_in_port_signal  in  1  CPU IN instruction; pop one word.
- o_in_data  out  DATA_WIDTH  word returned to the CPU; registered.
- o_in_empty  out  1  FIFO count == 0.
- i_out_port_signal  in  1  CPU OUT instruction.
- i_out_data  in  DATA_WIDTH  word to send.
- o_ext_out_valid  out  1  word pending to the device.
- o_ext_out_data  out  DATA_WIDTH  pending word; held stable while valid.
- i_ext_out_ready  in  1  device accepts the word.
- o_out_busy  out  1  high when the output state machine is in SEND.
- o_out_port_value  out  DATA_WIDTH  last word accepted by the device.
- i_clear_flags  in  1  clears the sticky flags.
- o_underflow  out  1  sticky: IN was issued while the FIFO was empty.
- o_overflow  out  1  sticky: OUT was dropped.

Behaviour:
- Reset: FIFO pointers and count = 0; all data outputs and flags = 0; o_ext_out_valid = 0; output state = IDLE.
- Reset mid-handshake discards any pending output word and all FIFO contents.
- Input FIFO push: on i_ext_in_valid && o_ext_in_ready, store the word at the write pointer. Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Input FIFO pop, FIFO non-empty: o_in_data <= head word on the edge where i_in_port_signal is sampled, giving 1-cycle latency. Read pointer advances.
- Input FIFO pop, FIFO empty: o_in_data <= 0 and o_underflow <= 1. No pointer moves.
- o_in_data holds its value when no IN is issued.
- Simultaneous push and pop on a non-empty, non-full FIFO: both occur and count is unchanged.
- Push and pop in the same cycle on an empty FIFO: the pop underflows (returns 0) and the push still succeeds, so count becomes 1.
- When the FIFO is full, ready = 0, so no push can occur even if a pop happens in the same cycle.
- Output state machine, IDLE: i_out_port_signal latches i_out_data into o_ext_out_data, sets valid = 1, and moves to SEND on the next edge.
- Output state machine, SEND:
  - i_ext_out_ready alone: transfer completes; o_out_port_value <= o_ext_out_data; valid = 0; go to IDLE.
  - i_ext_out_ready and i_out_port_signal in the same cycle: transfer completes, the new word is latched, and the state stays SEND with valid = 1 (back-to-back, no bubble).
  - i_out_port_signal without ready: the new word is dropped, o_overflow <= 1, and the pending word is unchanged.
- Sticky flags: i_clear_flags clears both flags. A set and a clear in the same cycle resolve to set.
- Handshake rule: o_ext_out_valid and o_ext_out_data are never changed while valid = 1 and ready = 0.

Test Plan:
- Reset; push 0x1111, 0x2222, 0x3333, 0x4444 → ready drops after the 4th push; IN ×4 → o_in_data = 0x1111…0x4444, one per cycle after each IN; o_in_empty = 1 after the last.
- Empty FIFO; IN → o_in_data = 0x0000 and o_underflow = 1; i_clear_flags → o_underflow = 0.
- FIFO holding 1 word (0xAAAA); push 0xBBBB together with IN → o_in_data = 0xAAAA, count stays 1, next IN returns 0xBBBB.
- OUT 0x00F0 with ready held low for 3 cycles → valid = 1 and data = 0x00F0 stable throughout; ready pulse → o_out_port_value = 0x00F0, valid = 0, o_out_busy = 0.
- In SEND, OUT 0x1234 with ready = 0 → o_overflow = 1 and the pending word is unchanged. Then ready together with OUT 0x5678 → the first word is accepted, valid stays 1, data = 0x5678.
- Assert i_reset while SEND with 2 FIFO entries → next cycle: valid = 0, o_in_empty = 1, all outputs zero.

Source files
------------

// File: rtl/io_port_bridge.sv
// rtl/io_port_bridge.sv - device-side end of the CPU IN/OUT port interface
//
// Purpose:
//   Input path: words offered by an external device go into a small FIFO.
//   Each CPU IN pops one word into a registered output. An IN on an empty
//   FIFO returns zero and raises the sticky underflow flag.
//   Output path: each CPU OUT word is held on a valid/ready handshake until
//   the device accepts it. Accept and a new OUT in the same cycle chain
//   back-to-back with no bubble. An OUT that arrives while a word is still
//   pending is dropped and raises the sticky overflow flag.
//
// Ports:
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_ext_in_valid/data   device offers a word to the input FIFO
//   o_ext_in_ready        FIFO not full
//   i_in_port_signal      CPU IN: pop one word
//   o_in_data             popped word, registered, held between INs
//   o_in_empty            FIFO empty
//   i_out_port_signal     CPU OUT: send i_out_data
//   o_ext_out_valid/data  pending word to the device
//   i_ext_out_ready       device accepts the pending word
//   o_out_busy            output machine is in SEND
//   o_out_port_value      last word accepted by the device
//   i_clear_flags         clear sticky flags (a same-cycle set wins)
//   o_underflow           sticky: IN issued on an empty FIFO
//   o_overflow            sticky: OUT dropped

module io_port_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ext_in_valid,
  input  logic [DATA_WIDTH-1:0] i_ext_in_data,
  output logic                  o_ext_in_ready,
  input  logic                  i_in_port_signal,
  output logic [DATA_WIDTH-1:0] o_in_data,
  output logic                  o_in_empty,
  input  logic                  i_out_port_signal,
  input  logic [DATA_WIDTH-1:0] i_out_data,
  output logic                  o_ext_out_valid,
  output logic [DATA_WIDTH-1:0] o_ext_out_data,
  input  logic                  i_ext_out_ready,
  output logic                  o_out_busy,
  output logic [DATA_WIDTH-1:0] o_out_port_value,
  input  logic                  i_clear_flags,
  output logic                  o_underflow,
  output logic                  o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  pop_empty;
  out_state_t            state;

  assign full           = (count == CNT_W'(FIFO_DEPTH));
  assign empty          = (count == '0);
  assign o_ext_in_ready = !full;
  assign o_in_empty     = empty;

  // Full blocks a push even when a pop frees a slot in the same cycle,
  // so ready stays a pure function of the registered count.
  assign push      = i_ext_in_valid && !full;
  assign pop       = i_in_port_signal && !empty;
  assign pop_empty = i_in_port_signal && empty;

  assign o_out_busy = (state == SEND);

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_ext_in_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_in_data   <= '0;
      o_underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_in_data <= mem[rd_ptr];
      end else if (pop_empty) begin
        o_in_data <= '0;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // Clear first so that a simultaneous set takes priority.
      if (i_clear_flags) begin
        o_underflow <= 1'b0;
      end
      if (pop_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= IDLE;
      o_ext_out_valid  <= 1'b0;
      o_ext_out_data   <= '0;
      o_out_port_value <= '0;
      o_overflow       <= 1'b0;
    end else begin
      if (i_clear_flags) begin
        o_overflow <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (i_out_port_signal) begin
            o_ext_out_data  <= i_out_data;
            o_ext_out_valid <= 1'b1;
            state           <= SEND;
          end
        end
        SEND: begin
          if (i_ext_out_ready) begin
            o_out_port_value <= o_ext_out_data;
            if (i_out_port_signal) begin
              // Chain the next word straight onto the bus, no idle cycle.
              o_ext_out_data <= i_out_data;
            end else begin
              o_ext_out_valid <= 1'b0;
              state           <= IDLE;
            end
          end else if (i_out_port_signal) begin
            // Pending word must stay stable; the new word is lost.
            o_overflow <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          o_ext_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// tb/tb_io_port_bridge.sv - directed self-checking bench for io_port_bridge

module tb_io_port_bridge;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          ext_in_valid;
  logic [DW-1:0] ext_in_data;
  logic          ext_in_ready;
  logic          in_port_signal;
  logic [DW-1:0] in_data;
  logic          in_empty;
  logic          out_port_signal;
  logic [DW-1:0] out_data;
  logic          ext_out_valid;
  logic [DW-1:0] ext_out_data;
  logic          ext_out_ready;
  logic          out_busy;
  logic [DW-1:0] out_port_value;
  logic          clear_flags;
  logic          underflow;
  logic          overflow;

  int pass_cnt = 0;
  int total    = 0;

  io_port_bridge #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_ext_in_valid    (ext_in_valid),
    .i_ext_in_data     (ext_in_data),
    .o_ext_in_ready    (ext_in_ready),
    .i_in_port_signal  (in_port_signal),
    .o_in_data         (in_data),
    .o_in_empty        (in_empty),
    .i_out_port_signal (out_port_signal),
    .i_out_data        (out_data),
    .o_ext_out_valid   (ext_out_valid),
    .o_ext_out_data    (ext_out_data),
    .i_ext_out_ready   (ext_out_ready),
    .o_out_busy        (out_busy),
    .o_out_port_value  (out_port_value),
    .i_clear_flags     (clear_flags),
    .o_underflow       (underflow),
    .o_overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if ({ext_out_valid, out_busy, underflow, overflow, in_empty, ext_in_ready} !== 6'b000011)
      $display("FAIL reset_ctrl: got %b want 000011", {ext_out_valid, out_busy, underflow, overflow, in_empty, ext_in_ready});
    else pass_cnt++;
    total++;
    if ({in_data, ext_out_data, out_port_value} !== 48'h0)
      $display("FAIL reset_data: got %h want 0", {in_data, ext_out_data, out_port_value});
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] vals [4];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      ext_in_valid = 1'b1;
      ext_in_data  = vals[i];
      step();
      if (i == 2) begin
        total++;
        if (ext_in_ready !== 1'b1) $display("FAIL fill_ready3: got %b want 1", ext_in_ready);
        else pass_cnt++;
      end
    end
    ext_in_valid = 1'b0;
    total++;
    if (ext_in_ready !== 1'b0) $display("FAIL fill_full: ready got %b want 0", ext_in_ready);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      in_port_signal = 1'b1;
      step();
      total++;
      if (in_data !== vals[i]) $display("FAIL drain_%0d: got %h want %h", i, in_data, vals[i]);
      else pass_cnt++;
    end
    in_port_signal = 1'b0;
    total++;
    if ({in_empty, underflow, ext_in_ready} !== 3'b101)
      $display("FAIL drain_end: empty/underflow/ready got %b want 101", {in_empty, underflow, ext_in_ready});
    else pass_cnt++;
    step();
    total++;
    if (in_data !== 16'h4444) $display("FAIL in_hold: got %h want 4444", in_data);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    in_port_signal = 1'b1;
    step();
    in_port_signal = 1'b0;
    total++;
    if ({in_data, underflow} !== {16'h0000, 1'b1})
      $display("FAIL underflow_set: data/flag got %h/%b want 0000/1", in_data, underflow);
    else pass_cnt++;
    clear_flags = 1'b1;
    step();
    total++;
    if (underflow !== 1'b0) $display("FAIL underflow_clear: got %b want 0", underflow);
    else pass_cnt++;
    in_port_signal = 1'b1;
    step();
    in_port_signal = 1'b0;
    clear_flags    = 1'b0;
    total++;
    if (underflow !== 1'b1) $display("FAIL set_beats_clear: got %b want 1", underflow);
    else pass_cnt++;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  task automatic test_simultaneous();
    ext_in_valid = 1'b1;
    ext_in_data  = 16'hAAAA;
    step();
    ext_in_data    = 16'hBBBB;
    in_port_signal = 1'b1;
    step();
    ext_in_valid = 1'b0;
    total++;
    if ({in_data, in_empty} !== {16'hAAAA, 1'b0})
      $display("FAIL simul_pop: data/empty got %h/%b want aaaa/0", in_data, in_empty);
    else pass_cnt++;
    step();
    in_port_signal = 1'b0;
    total++;
    if ({in_data, in_empty} !== {16'hBBBB, 1'b1})
      $display("FAIL simul_next: data/empty got %h/%b want bbbb/1", in_data, in_empty);
    else pass_cnt++;
    ext_in_valid   = 1'b1;
    ext_in_data    = 16'hCCCC;
    in_port_signal = 1'b1;
    step();
    ext_in_valid = 1'b0;
    total++;
    if ({in_data, underflow, in_empty} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL empty_pushpop: data/uf/empty got %h/%b/%b want 0000/1/0", in_data, underflow, in_empty);
    else pass_cnt++;
    step();
    in_port_signal = 1'b0;
    total++;
    if ({in_data, in_empty} !== {16'hCCCC, 1'b1})
      $display("FAIL empty_pushpop_next: data/empty got %h/%b want cccc/1", in_data, in_empty);
    else pass_cnt++;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  task automatic test_out_stall();
    out_port_signal = 1'b1;
    out_data        = 16'h00F0;
    step();
    out_port_signal = 1'b0;
    out_data        = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({ext_out_valid, out_busy, ext_out_data} !== {2'b11, 16'h00F0})
        $display("FAIL stall_%0d: valid/busy/data got %b/%b/%h want 1/1/00f0", i, ext_out_valid, out_busy, ext_out_data);
      else pass_cnt++;
      step();
    end
    ext_out_ready = 1'b1;
    step();
    ext_out_ready = 1'b0;
    total++;
    if ({out_port_value, ext_out_valid, out_busy, overflow} !== {16'h00F0, 3'b000})
      $display("FAIL stall_accept: value/valid/busy/ovf got %h/%b/%b/%b want 00f0/0/0/0", out_port_value, ext_out_valid, out_busy, overflow);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    out_port_signal = 1'b1;
    out_data        = 16'h0A0A;
    step();
    out_data = 16'h1234;
    step();
    out_port_signal = 1'b0;
    total++;
    if ({overflow, ext_out_valid, ext_out_data} !== {2'b11, 16'h0A0A})
      $display("FAIL overflow_drop: ovf/valid/data got %b/%b/%h want 1/1/0a0a", overflow, ext_out_valid, ext_out_data);
    else pass_cnt++;
    out_port_signal = 1'b1;
    out_data        = 16'h5678;
    ext_out_ready   = 1'b1;
    step();
    out_port_signal = 1'b0;
    total++;
    if ({out_port_value, ext_out_valid, out_busy, ext_out_data} !== {16'h0A0A, 2'b11, 16'h5678})
      $display("FAIL b2b_chain: value/valid/busy/data got %h/%b/%b/%h want 0a0a/1/1/5678", out_port_value, ext_out_valid, out_busy, ext_out_data);
    else pass_cnt++;
    step();
    ext_out_ready = 1'b0;
    total++;
    if ({out_port_value, ext_out_valid, out_busy} !== {16'h5678, 2'b00})
      $display("FAIL b2b_drain: value/valid/busy got %h/%b/%b want 5678/0/0", out_port_value, ext_out_valid, out_busy);
    else pass_cnt++;
    total++;
    if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b want 1", overflow);
    else pass_cnt++;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    total++;
    if (overflow !== 1'b0) $display("FAIL overflow_clear: got %b want 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ext_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ext_in_data = 16'h7000 + 16'(i);
      step();
    end
    ext_in_valid    = 1'b0;
    in_port_signal  = 1'b1;
    out_port_signal = 1'b1;
    out_data        = 16'hBEEF;
    step();
    in_port_signal = 1'b0;
    out_data       = 16'hDEAD;
    step();
    out_port_signal = 1'b0;
    total++;
    if ({in_data, ext_out_valid, overflow, in_empty} !== {16'h7000, 3'b110})
      $display("FAIL premid_state: data/valid/ovf/empty got %h/%b/%b/%b want 7000/1/1/0", in_data, ext_out_valid, overflow, in_empty);
    else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({ext_out_valid, out_busy, overflow, underflow, in_empty, ext_in_ready} !== 6'b000011)
      $display("FAIL midreset_ctrl: got %b want 000011", {ext_out_valid, out_busy, overflow, underflow, in_empty, ext_in_ready});
    else pass_cnt++;
    total++;
    if ({in_data, ext_out_data, out_port_value} !== 48'h0)
      $display("FAIL midreset_data: got %h want 0", {in_data, ext_out_data, out_port_value});
    else pass_cnt++;
    in_port_signal = 1'b1;
    step();
    in_port_signal = 1'b0;
    total++;
    if ({in_data, underflow} !== {16'h0000, 1'b1})
      $display("FAIL midreset_fifo_gone: data/uf got %h/%b want 0000/1", in_data, underflow);
    else pass_cnt++;
  endtask

  initial begin
    reset           = 1'b1;
    ext_in_valid    = 1'b0;
    ext_in_data     = '0;
    in_port_signal  = 1'b0;
    out_port_signal = 1'b0;
    out_data        = '0;
    ext_out_ready   = 1'b0;
    clear_flags     = 1'b0;
    #1;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_simultaneous();
    test_out_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
